pwm_compare: RTL and testbench
==============================

Name: pwm_compare

Overview:
- Downstream consumer of the shared counter block. Takes the counter's `count` value and the `en` strobe that drives the counter, and produces a PWM waveform plus event pulses.
- The compare threshold is double-buffered. A valid/ready write loads a shadow register, and the shadow transfers to the active register only at the period boundary, so the waveform never glitches mid-period.
- Sits between the timer counter and the pin/interrupt logic.

Parameters:
- COUNT_WIDTH, 8, bit width of count_in and all compare values.
- COUNT_FROM, 0, first count value of a period; must equal the counter's COUNT_FROM.
- COUNT_TO, (2**COUNT_WIDTH)-1, last count value of a period; must equal the counter's COUNT_TO.
- INVERT, 0, 1 inverts pwm_out polarity and the idle level.
- CMP_RESET, 0, value of the active and shadow compare registers after reset.

Ports:
- clk  input  1  clock, same clock as the counter.
- rst  input  1  reset, asynchronous, active-low.
- count_in  input  COUNT_WIDTH  counter output.
- count_en  input  1  counter enable; count_in advances on the next edge when high.
- pwm_en  input  1  output enable; low forces pwm_out to the idle level.
- cmp_wdata  input  COUNT_WIDTH  new compare value.
- cmp_wvalid  input  1  write request.
- cmp_wready  output  1  high when the shadow register is free.
- pwm_out  output  1  registered PWM output.
- match_pulse  output  1  one-cycle compare event.
- period_pulse  output  1  one-cycle period-end event.
- cmp_active  output  COUNT_WIDTH  compare value currently in effect.

Behaviour:
- Reset (rst=0, asynchronous assert, synchronous release):
  - cmp_active = CMP_RESET, shadow = CMP_RESET, pending = 0.
  - cmp_wready = 1.
  - pwm_out = INVERT.
  - match_pulse = 0, period_pulse = 0.
  - Reset mid-period discards any pending write.
- Boundary event: count_en=1 and count_in==COUNT_TO in cycle N. The counter shows COUNT_FROM in cycle N+1.
- Write handshake:
  - A write is accepted on a clock edge where cmp_wvalid=1 and cmp_wready=1.
  - On acceptance, shadow <= cmp_wdata, pending <= 1, and cmp_wready = 0 from the next cycle.
  - cmp_wready = !pending, registered. wvalid held while wready=0 is not accepted and is not lost; the requester holds it.
- Shadow transfer:
  - At the edge ending a boundary cycle with pending=1: cmp_active <= shadow, pending <= 0. cmp_active is therefore the new value in cycle N+1.
  - A write accepted in the boundary cycle itself (pending was 0) does not transfer at that edge. It takes effect at the following boundary.
- PWM output, one-cycle latency, registered:
  - pwm_out <= pwm_en ? ((count_in < cmp_active) ^ INVERT) : INVERT.
  - The comparison uses the cmp_active value of the current cycle, i.e. the new value is already used when count_in==COUNT_FROM.
- Duty boundaries:
  - cmp_active <= COUNT_FROM gives a constant inactive level.
  - cmp_active > COUNT_TO gives a constant active level.
  - Comparison is unsigned, full COUNT_WIDTH, with no wrap arithmetic.
- Counter stalled (count_en=0):
  - pwm_out keeps tracking count_in.
  - No events fire.
  - No shadow transfer occurs.
- period_pulse <= boundary event, registered: high exactly in cycle N+1.
- match_pulse <= count_en && (count_in == cmp_active), registered.
  - Fires once per period, on the cycle after the counter advances away from the compare value.
  - Never fires if cmp_active lies outside COUNT_FROM..COUNT_TO.
- Simultaneous events: when match and boundary coincide (cmp_active==COUNT_TO), match_pulse uses the old cmp_active and both pulses assert together.
- pwm_en only gates pwm_out. The handshake, transfer and pulses operate regardless of pwm_en.

Test Plan:
- Reset and steady state:
  - Stimulus: assert rst=0 mid-stream, then release. Defaults: COUNT_WIDTH=8, CMP_RESET=0.
  - Response: pwm_out=0 and cmp_wready=1; cmp_active=0 and pwm_out stays 0 for a full period.
- Duty with deferred update:
  - Stimulus: write 64 at count_in=10.
  - Response: wready drops the next cycle; cmp_active stays 0 until the cycle after count_in=255.
  - Response: pwm_out is 1 for exactly 64 cycles per period from then on; wready returns to 1 after the transfer.
- Back-to-back writes:
  - Stimulus: write 100, then hold wvalid with 200.
  - Response: 200 is accepted only after the boundary that applies 100, and is applied one period later.
- Write in the boundary cycle:
  - Stimulus: write 32 accepted while count_in=255 and count_en=1.
  - Response: cmp_active is unchanged at that boundary and becomes 32 at the next one.
- Extremes and events:
  - Stimulus: cmp=0, then cmp=255, then COUNT_TO=9 with cmp=9.
  - Response (cmp=0): pwm_out constantly 0.
  - Response (cmp=255): pwm_out low only at count 255.
  - Response (COUNT_TO=9, cmp=9): match_pulse and period_pulse assert together once every 10 enabled counts.
- Stall and gating:
  - Stimulus: hold count_en=0 at count 250 for 5 cycles, with pwm_en=0 and INVERT=1.
  - Response: no pulses, no transfer, pwm_out=1 throughout.

Source files
------------

// File: rtl/pwm_compare.sv
// rtl/pwm_compare.sv - double-buffered PWM compare stage driven by the shared timer counter
`timescale 1ns/1ps
module pwm_compare #(
  parameter int COUNT_WIDTH = 8,
  parameter int COUNT_FROM  = 0,
  parameter int COUNT_TO    = (2**COUNT_WIDTH)-1,
  parameter bit INVERT      = 1'b0,
  parameter int CMP_RESET   = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [COUNT_WIDTH-1:0] count_in,
  input  logic                   count_en,
  input  logic                   pwm_en,
  input  logic [COUNT_WIDTH-1:0] cmp_wdata,
  input  logic                   cmp_wvalid,
  output logic                   cmp_wready,
  output logic                   pwm_out,
  output logic                   match_pulse,
  output logic                   period_pulse,
  output logic [COUNT_WIDTH-1:0] cmp_active
);

  localparam logic [COUNT_WIDTH-1:0] TO_V  = COUNT_TO[COUNT_WIDTH-1:0];
  localparam logic [COUNT_WIDTH-1:0] RST_V = CMP_RESET[COUNT_WIDTH-1:0];

  logic [COUNT_WIDTH-1:0] cmp_active_q, cmp_active_d;
  logic [COUNT_WIDTH-1:0] shadow_q, shadow_d;
  logic                   pending_q, pending_d;
  logic                   pwm_q, pwm_d;
  logic                   match_q, match_d;
  logic                   period_q, period_d;

  logic boundary;
  logic accept;
  logic in_range;

  assign boundary = count_en && (count_in == TO_V);
  assign accept   = cmp_wvalid && !pending_q;
  // A compare value outside the counting range can never be reached by the counter.
  assign in_range = (int'(cmp_active_q) >= COUNT_FROM) && (int'(cmp_active_q) <= COUNT_TO);

  always_comb begin
    cmp_active_d = cmp_active_q;
    shadow_d     = shadow_q;
    pending_d    = pending_q;
    pwm_d        = INVERT;
    match_d      = 1'b0;
    period_d     = boundary;

    if (accept) begin
      shadow_d  = cmp_wdata;
      pending_d = 1'b1;
    end

    // accept needs !pending_q, so it never collides with a transfer at the same edge.
    if (boundary && pending_q) begin
      cmp_active_d = shadow_q;
      pending_d    = 1'b0;
    end

    if (pwm_en) begin
      pwm_d = (count_in < cmp_active_q) ^ INVERT;
    end

    match_d = count_en && in_range && (count_in == cmp_active_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmp_active_q <= RST_V;
      shadow_q     <= RST_V;
      pending_q    <= 1'b0;
      pwm_q        <= INVERT;
      match_q      <= 1'b0;
      period_q     <= 1'b0;
    end else begin
      cmp_active_q <= cmp_active_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      pwm_q        <= pwm_d;
      match_q      <= match_d;
      period_q     <= period_d;
    end
  end

  assign cmp_wready   = !pending_q;
  assign pwm_out      = pwm_q;
  assign match_pulse  = match_q;
  assign period_pulse = period_q;
  assign cmp_active   = cmp_active_q;

endmodule

// File: tb/tb_pwm_compare.sv
// tb/tb_pwm_compare.sv - randomized bench for pwm_compare against a behavioural model
`timescale 1ns/1ps
module tb_pwm_compare;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       count_en = 1'b0;
  logic       pwm_en = 1'b0;
  logic       wvalid = 1'b0;
  logic [7:0] wdata = 8'd0;
  logic [7:0] c_in [N];
  logic       w_rdy [N];
  logic       pwm_o [N];
  logic       match_o [N];
  logic       period_o [N];
  logic [7:0] act_o [N];

  // Instance 0: defaults, 1: inverted polarity, 2: short period 0..9.
  pwm_compare u0 (
    .clk(clk), .rst(rst), .count_in(c_in[0]), .count_en(count_en), .pwm_en(pwm_en),
    .cmp_wdata(wdata), .cmp_wvalid(wvalid), .cmp_wready(w_rdy[0]), .pwm_out(pwm_o[0]),
    .match_pulse(match_o[0]), .period_pulse(period_o[0]), .cmp_active(act_o[0]));
  pwm_compare #(.INVERT(1'b1)) u1 (
    .clk(clk), .rst(rst), .count_in(c_in[1]), .count_en(count_en), .pwm_en(pwm_en),
    .cmp_wdata(wdata), .cmp_wvalid(wvalid), .cmp_wready(w_rdy[1]), .pwm_out(pwm_o[1]),
    .match_pulse(match_o[1]), .period_pulse(period_o[1]), .cmp_active(act_o[1]));
  pwm_compare #(.COUNT_TO(9)) u2 (
    .clk(clk), .rst(rst), .count_in(c_in[2]), .count_en(count_en), .pwm_en(pwm_en),
    .cmp_wdata(wdata), .cmp_wvalid(wvalid), .cmp_wready(w_rdy[2]), .pwm_out(pwm_o[2]),
    .match_pulse(match_o[2]), .period_pulse(period_o[2]), .cmp_active(act_o[2]));

  int to_v [N]  = '{255, 255, 9};
  bit inv_v [N] = '{1'b0, 1'b1, 1'b0};

  int m_cnt [N];
  int m_act [N];
  int m_sh [N];
  bit m_pend [N];
  bit m_pwm [N];
  bit m_match [N];
  bit m_per [N];
  bit m_acc [N];

  int total = 0;
  int bad = 0;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0; m_act[i] = 0; m_sh[i] = 0; m_pend[i] = 0;
      m_pwm[i] = inv_v[i]; m_match[i] = 0; m_per[i] = 0; m_acc[i] = 0;
      c_in[i] = 8'd0;
    end
  endtask

  // One clock: evaluate the rules on the current inputs, then move to #1 after the edge.
  task automatic step();
    int n_cnt [N];
    int n_act [N];
    int n_sh [N];
    bit n_pend [N];
    bit n_pwm [N];
    bit n_match [N];
    bit n_per [N];
    bit n_acc [N];
    for (int i = 0; i < N; i++) begin
      bit bnd;
      bnd = count_en && (m_cnt[i] == to_v[i]);
      n_acc[i] = wvalid && !m_pend[i];
      n_act[i] = m_act[i];
      n_sh[i] = n_acc[i] ? int'(wdata) : m_sh[i];
      n_pend[i] = m_pend[i] | n_acc[i];
      if (bnd && m_pend[i]) begin
        n_act[i] = m_sh[i];
        n_pend[i] = 0;
      end
      n_pwm[i] = pwm_en ? ((m_cnt[i] < m_act[i]) ^ inv_v[i]) : inv_v[i];
      n_match[i] = count_en && (m_cnt[i] == m_act[i]);
      n_per[i] = bnd;
      n_cnt[i] = !count_en ? m_cnt[i] : (m_cnt[i] == to_v[i]) ? 0 : m_cnt[i] + 1;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = n_cnt[i]; m_act[i] = n_act[i]; m_sh[i] = n_sh[i]; m_pend[i] = n_pend[i];
      m_pwm[i] = n_pwm[i]; m_match[i] = n_match[i]; m_per[i] = n_per[i]; m_acc[i] = n_acc[i];
      c_in[i] = 8'(m_cnt[i]);
    end
  endtask

  task automatic run_to(input int v);
    int k;
    for (k = 0; k < 600; k++) begin
      if (m_cnt[0] == v) break;
      step();
    end
    total++;
    if (k == 600) begin
      bad++;
      $display("FAIL run_to: count %0d not reached, at %0d", v, m_cnt[0]);
    end
  endtask

  task automatic write_all(input logic [7:0] v);
    bit got [N] = '{default: 1'b0};
    int k;
    wdata = v;
    wvalid = 1'b1;
    for (k = 0; k < 600; k++) begin
      step();
      for (int i = 0; i < N; i++) if (m_acc[i]) got[i] = 1'b1;
      if (got[0] && got[1] && got[2]) break;
    end
    wvalid = 1'b0;
    for (k = 0; k < 600; k++) begin
      if (!m_pend[0] && !m_pend[1] && !m_pend[2]) break;
      step();
    end
    total++;
    if (k == 600 || act_o[0] !== v) begin
      bad++;
      $display("FAIL write_all: cmp_active got %0d want %0d", act_o[0], v);
    end
  endtask

  task automatic test_reset();
    count_en = 1'b0; pwm_en = 1'b1; wvalid = 1'b0; wdata = 8'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    count_en = 1'b1;
    repeat (20) step();
    wdata = 8'd77; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    repeat (5) step();
    total++;
    if (w_rdy[0] !== 1'b0) begin
      bad++; $display("FAIL pre_reset_wready: got %0d want 0", w_rdy[0]);
    end
    #2 rst = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < N; i++) begin
      total++;
      if (pwm_o[i] !== inv_v[i] || w_rdy[i] !== 1'b1 || act_o[i] !== 8'd0 ||
          match_o[i] !== 1'b0 || period_o[i] !== 1'b0) begin
        bad++;
        $display("FAIL reset_state[%0d]: pwm=%0d rdy=%0d act=%0d m=%0d p=%0d want %0d/1/0/0/0",
                 i, pwm_o[i], w_rdy[i], act_o[i], match_o[i], period_o[i], inv_v[i]);
      end
    end
    @(posedge clk);
    #1 rst = 1'b1;
    for (int k = 0; k < 256; k++) begin
      step();
      total++;
      if (pwm_o[0] !== 1'b0 || act_o[0] !== 8'd0 || w_rdy[0] !== 1'b1) begin
        bad++;
        $display("FAIL reset_period: pwm=%0d act=%0d rdy=%0d want 0/0/1", pwm_o[0], act_o[0], w_rdy[0]);
      end
    end
  endtask

  task automatic test_duty_deferred();
    bit seen;
    int k;
    int hi;
    count_en = 1'b1; pwm_en = 1'b1;
    run_to(10);
    wdata = 8'd64; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    total++;
    if (w_rdy[0] !== 1'b0) begin
      bad++; $display("FAIL duty_wready_drop: got %0d want 0", w_rdy[0]);
    end
    seen = 0;
    for (k = 0; k < 300 && !seen; k++) begin
      bit bnd;
      bnd = (m_cnt[0] == 255);
      step();
      if (bnd) seen = 1;
      total++;
      if (act_o[0] !== (seen ? 8'd64 : 8'd0)) begin
        bad++; $display("FAIL duty_deferred: act got %0d want %0d", act_o[0], seen ? 64 : 0);
      end
    end
    total++;
    if (w_rdy[0] !== 1'b1) begin
      bad++; $display("FAIL duty_wready_back: got %0d want 1", w_rdy[0]);
    end
    for (int p = 0; p < 2; p++) begin
      hi = 0;
      for (int j = 0; j < 256; j++) begin
        step();
        hi += int'(pwm_o[0]);
      end
      total++;
      if (hi != 64) begin
        bad++; $display("FAIL duty_high_cycles: got %0d want 64", hi);
      end
    end
  endtask

  task automatic test_back_to_back();
    int k;
    int t100;
    int t200;
    count_en = 1'b1; pwm_en = 1'b1;
    wdata = 8'd100; wvalid = 1'b1;
    for (k = 0; k < 600; k++) begin
      step();
      if (m_acc[0]) break;
    end
    wdata = 8'd200;
    t100 = -1;
    for (k = 0; k < 600; k++) begin
      step();
      if (t100 < 0 && act_o[0] === 8'd100) t100 = k;
      if (m_acc[0]) break;
    end
    total++;
    if (act_o[0] !== 8'd100 || k == 600) begin
      bad++; $display("FAIL b2b_second_accept: act got %0d want 100 when 200 accepted", act_o[0]);
    end
    wvalid = 1'b0;
    t200 = -1;
    for (k = k + 1; k < 1200; k++) begin
      step();
      if (act_o[0] === 8'd200) begin t200 = k; break; end
    end
    total++;
    if (t100 < 0 || t200 - t100 != 256) begin
      bad++; $display("FAIL b2b_apply_gap: got %0d cycles want 256", t200 - t100);
    end
  endtask

  task automatic test_boundary_write();
    logic [7:0] prev;
    count_en = 1'b1; pwm_en = 1'b1;
    run_to(255);
    prev = act_o[0];
    wdata = 8'd32; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    total++;
    if (w_rdy[0] !== 1'b0 || act_o[0] !== prev) begin
      bad++; $display("FAIL bwrite_edge: rdy=%0d act=%0d want 0/%0d", w_rdy[0], act_o[0], prev);
    end
    for (int k = 1; k <= 256; k++) begin
      step();
      total++;
      if (act_o[0] !== ((k == 256) ? 8'd32 : prev)) begin
        bad++; $display("FAIL bwrite_defer k=%0d: act got %0d want %0d", k, act_o[0], (k == 256) ? 32 : prev);
      end
    end
  endtask

  task automatic test_extremes();
    int lows;
    int both;
    int single;
    count_en = 1'b1; pwm_en = 1'b1;
    write_all(8'd0);
    step();
    for (int k = 0; k < 256; k++) begin
      step();
      total++;
      if (pwm_o[0] !== 1'b0) begin
        bad++; $display("FAIL cmp0_pwm: got %0d want 0", pwm_o[0]);
      end
    end
    write_all(8'd255);
    step();
    lows = 0;
    for (int k = 0; k < 256; k++) begin
      int pc;
      pc = m_cnt[0];
      step();
      if (!pwm_o[0]) lows++;
      total++;
      if (pwm_o[0] !== (pc != 255)) begin
        bad++; $display("FAIL cmp255_pwm cnt=%0d: got %0d want %0d", pc, pwm_o[0], pc != 255);
      end
    end
    total++;
    if (lows != 1) begin
      bad++; $display("FAIL cmp255_lows: got %0d want 1", lows);
    end
    write_all(8'd9);
    both = 0; single = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      if (match_o[2] && period_o[2]) both++;
      else if (match_o[2] || period_o[2]) single++;
    end
    total++;
    if (both != 5 || single != 0) begin
      bad++; $display("FAIL short_events: together=%0d alone=%0d want 5/0", both, single);
    end
  endtask

  task automatic test_stall_gating();
    logic [7:0] a0;
    count_en = 1'b1; pwm_en = 1'b0;
    run_to(240);
    a0 = act_o[0];
    wdata = 8'd77; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    for (int phase = 0; phase < 2; phase++) begin
      count_en = 1'b1;
      run_to(phase == 0 ? 250 : 255);
      count_en = 1'b0;
      for (int k = 0; k < 6; k++) begin
        step();
        total++;
        if (pwm_o[1] !== 1'b1 || pwm_o[0] !== 1'b0 || act_o[0] !== a0 || w_rdy[0] !== 1'b0 ||
            (k > 0 && (match_o[0] || period_o[0] || match_o[1] || period_o[1] ||
                       match_o[2] || period_o[2]))) begin
          bad++;
          $display("FAIL stall k=%0d: pwm1=%0d pwm0=%0d act=%0d rdy=%0d m0=%0d p0=%0d want 1/0/%0d/0/0/0",
                   k, pwm_o[1], pwm_o[0], act_o[0], w_rdy[0], match_o[0], period_o[0], a0);
        end
      end
    end
    count_en = 1'b1;
    step();
    total++;
    if (act_o[0] !== 8'd77 || pwm_o[1] !== 1'b1) begin
      bad++; $display("FAIL stall_release: act=%0d pwm1=%0d want 77/1", act_o[0], pwm_o[1]);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      count_en = ($urandom_range(0, 3) != 0);
      pwm_en = ($urandom_range(0, 4) != 0);
      if (!wvalid || $urandom_range(0, 7) == 0) begin
        wvalid = $urandom_range(0, 1);
        wdata = 8'($urandom_range(0, 255));
      end
      step();
      for (int i = 0; i < N; i++) begin
        total++;
        if (pwm_o[i] !== m_pwm[i] || match_o[i] !== m_match[i] || period_o[i] !== m_per[i] ||
            w_rdy[i] !== !m_pend[i] || act_o[i] !== 8'(m_act[i])) begin
          bad++;
          $display("FAIL random[%0d] k=%0d: pwm=%0d m=%0d p=%0d rdy=%0d act=%0d want %0d/%0d/%0d/%0d/%0d",
                   i, k, pwm_o[i], match_o[i], period_o[i], w_rdy[i], act_o[i],
                   m_pwm[i], m_match[i], m_per[i], !m_pend[i], m_act[i]);
        end
      end
    end
    wvalid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_duty_deferred();
    test_back_to_back();
    test_boundary_write();
    test_extremes();
    test_stall_gating();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
